// File: rtl/reg_file_stk.sv
// reg_file_stk: parametrised general-purpose register file with two
// combinational read ports (A/B) and one synchronous write port. The top
// register (index NUM_REGS-1) is the hardware stack pointer (SP). It supports
// push/pop step control, bounds checking, sticky overflow/underflow flags and
// a live stack-depth output.
//
// Optional feature: define BYPASS_EN to enable write-to-read forwarding. A
// read port whose address matches an active write returns wr_data in the same
// cycle. On port A, the pop-read value (SP+1) still takes precedence over the
// forwarded data.
module reg_file_stk #(
  parameter int                DATA_W   = 8,
  parameter int                NUM_REGS = 4,
  parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] SP_FLOOR = '0,
  localparam int               AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  input  logic              sp_inc,
  input  logic              sp_dec,
  input  logic              flt_clr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] sp_value,
  output logic [DATA_W-1:0] depth,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam logic [AW-1:0] SP_IDX = AW'(NUM_REGS - 1);

  // SP lives in the top slot, so reads of SP_IDX need no special case.
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] sp_next;
  logic              ovf_hit;
  logic              unf_hit;

  assign sp       = regs[SP_IDX];
  assign sp_value = sp;
  assign depth    = SP_RESET - sp;

  // Resolve the next SP value and any new fault, highest priority first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sp_next = sp;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    if (we && wr_addr == SP_IDX) begin
      sp_next = wr_data;
    end else if (sp_inc && sp_dec) begin
      sp_next = sp;
    end else if (sp_inc) begin
      if (sp == SP_RESET) unf_hit = 1'b1;
      else                sp_next = sp + DATA_W'(1);
    end else if (sp_dec) begin
      if (sp == SP_FLOOR) ovf_hit = 1'b1;
      else                sp_next = sp - DATA_W'(1);
    end
  end

  // Register array, SP and sticky fault flags; reset overrides every operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly because software relies on R0..Rn-2 reading zero.
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
      regs[SP_IDX] <= SP_RESET;
      stk_ovf      <= 1'b0;
      stk_unf      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (we && wr_addr != SP_IDX) regs[wr_addr] <= wr_data;
      regs[SP_IDX] <= sp_next;
      stk_ovf      <= ovf_hit | (stk_ovf & ~flt_clr);
      stk_unf      <= unf_hit | (stk_unf & ~flt_clr);
    end
  end

  // Combinational read ports, with optional forwarding and the pop-read override.
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
`ifdef BYPASS_EN
    if (we && wr_addr == ra_addr) ra_data = wr_data;
    if (we && wr_addr == rb_addr) rb_data = wr_data;
`else
`endif
    if (ra_addr == SP_IDX && sp_inc) ra_data = sp + DATA_W'(1);
  end

endmodule

// File: tb/tb_reg_file_stk.sv
// Self-checking bench for reg_file_stk with default parameters (8-bit, 4 regs).
// A behavioural model tracks the register contents, SP and fault flags from
// the stack rules. A negedge compare process checks every output against it.
// Directed literal checks pin the model's behaviour on the documented
// scenarios. These are followed by a randomized phase.
module tb_reg_file_stk;

  logic       clk = 1'b0;
  logic       rst, we, sp_inc, sp_dec, flt_clr;
  logic [1:0] wr_addr, ra_addr, rb_addr;
  logic [7:0] wr_data;
  logic [7:0] ra_data, rb_data, sp_value, depth;
  logic       stk_ovf, stk_unf;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_stk dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .flt_clr(flt_clr), .ra_data(ra_data), .rb_data(rb_data),
    .sp_value(sp_value), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_valid = 1'b0;
  bit [7:0] m_gp [3];
  bit [7:0] m_sp;
  bit       m_ovf, m_unf;

  always @(posedge clk) begin
    bit new_ovf, new_unf;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (rst) begin
      foreach (m_gp[i]) m_gp[i] = 8'h00;
      m_sp    = 8'hFF;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (we && wr_addr == 2'd3)  m_sp = wr_data;
      else if (sp_inc && sp_dec) m_sp = m_sp;
      else if (sp_inc) begin
        if (m_sp == 8'hFF) new_unf = 1'b1;
        else               m_sp = m_sp + 8'd1;
      end else if (sp_dec) begin
        if (m_sp == 8'h00) new_ovf = 1'b1;
        else               m_sp = m_sp - 8'd1;
      end
      if (we && wr_addr != 2'd3) m_gp[wr_addr] = wr_data;
      m_ovf = new_ovf || (m_ovf && !flt_clr);
      m_unf = new_unf || (m_unf && !flt_clr);
    end
  end

  function automatic bit [7:0] exp_rd(input logic [1:0] a, input bit port_a);
    bit [7:0] v;
    if (a == 2'd3) v = m_sp;
    else           v = m_gp[a];
`ifdef BYPASS_EN
    if (we && wr_addr == a) v = wr_data;
`endif
    if (port_a && a == 2'd3 && sp_inc) v = m_sp + 8'd1;
    return v;
  endfunction

  // Compare every output against the model once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_ra_data",  ra_data,  exp_rd(ra_addr, 1'b1));
      check("cmp_rb_data",  rb_data,  exp_rd(rb_addr, 1'b0));
      check("cmp_sp_value", sp_value, m_sp);
      check("cmp_depth",    depth,    8'hFF - m_sp);
      check("cmp_stk_ovf",  stk_ovf,  m_ovf);
      check("cmp_stk_unf",  stk_unf,  m_unf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0; flt_clr = 1'b0;
    wr_addr = 2'd0; wr_data = 8'h00; ra_addr = 2'd0; rb_addr = 2'd0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;

    // 1. reset state
    for (int i = 0; i < 3; i++) begin
      ra_addr = 2'(i);
      rb_addr = 2'(i);
      #1;
      check("rst_ra_zero", ra_data, 8'h00);
      check("rst_rb_zero", rb_data, 8'h00);
    end
    check("rst_sp",    sp_value, 8'hFF);
    check("rst_depth", depth,    8'h00);
    check("rst_ovf",   stk_ovf,  1'b0);
    check("rst_unf",   stk_unf,  1'b0);
    check("model_rst_sp", m_sp, 8'hFF);

    // 2. write R1 = 0x5A; same-cycle visibility depends on forwarding
    ra_addr = 2'd1; we = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A;
    #1;
`ifdef BYPASS_EN
    check("wr_same_cycle", ra_data, 8'h5A);
`else
    check("wr_same_cycle", ra_data, 8'h00);
`endif
    cyc();
    we = 1'b0;
    #1;
    check("wr_next_cycle", ra_data, 8'h5A);

    // 3. three pushes, then a pop read on port A
    sp_dec = 1'b1;
    repeat (3) cyc();
    sp_dec = 1'b0;
    #1;
    check("push3_sp",    sp_value, 8'hFC);
    check("push3_depth", depth,    8'h03);
    check("model_push3_sp", m_sp, 8'hFC);
    sp_inc = 1'b1; ra_addr = 2'd3;
    #1;
    check("pop_read", ra_data, 8'hFD);
    cyc();
    sp_inc = 1'b0;
    #1;
    check("pop_sp", sp_value, 8'hFD);

    // 4. underflow at SP_RESET, pop read wraps, then clear
    sp_inc = 1'b1;
    repeat (2) cyc();
    #1;
    check("pop_to_top", sp_value, 8'hFF);
    check("pop_read_wrap", ra_data, 8'h00);
    cyc();
    check("unf_sp_held", sp_value, 8'hFF);
    check("unf_set",     stk_unf,  1'b1);
    sp_inc = 1'b0; flt_clr = 1'b1;
    cyc();
    flt_clr = 1'b0;
    check("unf_cleared", stk_unf, 1'b0);

    // 5. overflow at SP_FLOOR; fault beats clear in the same cycle
    we = 1'b1; wr_addr = 2'd3; wr_data = 8'h00;
    cyc();
    we = 1'b0; sp_dec = 1'b1;
    cyc();
    check("ovf_sp_held", sp_value, 8'h00);
    check("ovf_set",     stk_ovf,  1'b1);
    check("ovf_depth",   depth,    8'hFF);
    flt_clr = 1'b1;
    cyc();
    check("ovf_beats_clr", stk_ovf, 1'b1);
    sp_dec = 1'b0;
    cyc();
    flt_clr = 1'b0;
    check("ovf_cleared", stk_ovf, 1'b0);

    // 6. SP write beats pop; inc+dec together is a no-op
    we = 1'b1; wr_addr = 2'd3; wr_data = 8'h40; sp_inc = 1'b1;
    cyc();
    we = 1'b0;
    check("spwr_wins", sp_value, 8'h40);
    sp_dec = 1'b1;
    cyc();
    sp_inc = 1'b0; sp_dec = 1'b0;
    check("incdec_sp",  sp_value, 8'h40);
    check("incdec_ovf", stk_ovf,  1'b0);
    check("incdec_unf", stk_unf,  1'b0);

    // non-SP write alongside a push: both take effect
    we = 1'b1; wr_addr = 2'd2; wr_data = 8'hC3; sp_dec = 1'b1; ra_addr = 2'd2;
    cyc();
    idle();
    ra_addr = 2'd2;
    #1;
    check("gpwr_push_data", ra_data,  8'hC3);
    check("gpwr_push_sp",   sp_value, 8'h3F);

    // reset wins over a same-cycle write and push
    rst = 1'b1; we = 1'b1; wr_addr = 2'd2; wr_data = 8'h77; sp_dec = 1'b1;
    cyc();
    idle();
    ra_addr = 2'd2;
    #1;
    check("rst_wins_data", ra_data,  8'h00);
    check("rst_wins_sp",   sp_value, 8'hFF);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      we      = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      if (wr_addr == 2'd3) begin
        case ($urandom_range(0, 4))
          0: wr_data = 8'h00;
          1: wr_data = 8'h01;
          2: wr_data = 8'hFE;
          3: wr_data = 8'hFF;
          default: ;
        endcase
      end
      ra_addr = 2'($urandom_range(0, 3));
      rb_addr = 2'($urandom_range(0, 3));
      sp_inc  = ($urandom_range(0, 2) == 0);
      sp_dec  = ($urandom_range(0, 2) == 0);
      flt_clr = ($urandom_range(0, 7) == 0);
      cyc();
    end

    idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
